// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the IF stage: direct-mapped BTB with 2-bit counters,
// trained by control-flow instructions resolved in EX.
module branch_predictor #(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_IF_pc,
    output logic        o_IF_pred_taken,
    output logic [31:0] o_IF_next_pc,
    input  logic        i_EX_vld,
    input  logic        i_EX_is_jump,
    input  logic [31:0] i_EX_pc,
    input  logic        i_EX_taken,
    input  logic [31:0] i_EX_target,
    input  logic        i_EX_pred_taken,
    input  logic [31:0] i_EX_pred_target,
    output logic        o_mispred,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [31:0] br_count_q, br_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;

    logic        upd_en;
    logic [1:0]  ctr_d;
    logic [31:0] target_d;

    // Word-offset bits of both PCs carry no information for the predictor.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{i_IF_pc[1:0], i_EX_pc[1:0]};

    assign if_idx = i_IF_pc[IDX_W+1:2];
    assign if_tag = i_IF_pc[31:IDX_W+2];
    assign ex_idx = i_EX_pc[IDX_W+1:2];
    assign ex_tag = i_EX_pc[31:IDX_W+2];

    // Lookup reads the registered arrays, so a same-cycle update is not visible yet.
    always_comb begin
        if_hit          = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        o_IF_pred_taken = if_hit && ctr_q[if_idx][1];
        o_IF_next_pc    = o_IF_pred_taken ? target_q[if_idx] : i_IF_pc + 32'd4;
    end

    always_comb begin
        ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        upd_en   = 1'b0;
        ctr_d    = ctr_q[ex_idx];
        target_d = target_q[ex_idx];
        if (i_EX_vld) begin
            if (ex_hit) begin
                upd_en = 1'b1;
                if (i_EX_is_jump) begin
                    ctr_d    = 2'b11;
                    target_d = i_EX_target;
                end else if (i_EX_taken) begin
                    ctr_d    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                    target_d = i_EX_target;
                end else begin
                    ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
                end
            end else if (i_EX_taken) begin
                upd_en   = 1'b1;
                ctr_d    = i_EX_is_jump ? 2'b11 : 2'b10;
                target_d = i_EX_target;
            end
        end
    end

    always_comb begin
        o_mispred = i_EX_vld && ((i_EX_taken != i_EX_pred_taken) ||
                                 (i_EX_taken && (i_EX_target != i_EX_pred_target)));
        o_redirect_pc   = i_EX_taken ? i_EX_target : i_EX_pc + 32'd4;
        br_count_d      = i_EX_vld ? br_count_q + 32'd1 : br_count_q;
        mispred_count_d = o_mispred ? mispred_count_q + 32'd1 : mispred_count_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q         <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
            if (upd_en) begin
                valid_q[ex_idx] <= 1'b1;
                ctr_q[ex_idx]   <= ctr_d;
            end
        end
    end

    // Tags and targets need no reset; valid bits gate their use.
    always_ff @(posedge i_clk) begin
        if (!i_reset && upd_en) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= target_d;
        end
    end

    assign o_br_count      = br_count_q;
    assign o_mispred_count = mispred_count_q;

endmodule

// File: doc/branch_predictor.md
Name:
branch_predictor

Overview:
- Dynamic branch predictor with a branch target buffer (BTB) for the IF stage of the pipelined RV32I core.
- Looks up the current fetch PC in the same cycle and supplies the predicted next PC to the PC register.
- Is trained by branches and jumps resolved in EX, and flags mispredictions so the stall/flush unit can flush IF/ID and ID/EX.
- Replaces the current static "PC+4, redirect on EX taken" fetch policy.

Parameters:
ENTRIES, 64, number of BTB/counter entries; power of two, 4..1024
IDX_W, $clog2(ENTRIES), index width; derived, do not override

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  synchronous, active-high reset
i_IF_pc  input  32  current fetch PC
o_IF_pred_taken  output  1  prediction for i_IF_pc: 1 = taken
o_IF_next_pc  output  32  predicted next fetch PC
i_EX_vld  input  1  EX holds a valid, non-flushed, non-stalled control-flow instruction (branch, jal or jalr)
i_EX_is_jump  input  1  EX instruction is jal or jalr
i_EX_pc  input  32  PC of the EX instruction
i_EX_taken  input  1  resolved direction
i_EX_target  input  32  resolved target (ALU result)
i_EX_pred_taken  input  1  prediction carried down the pipe with the instruction
i_EX_pred_target  input  32  predicted next PC carried down the pipe
o_mispred  output  1  misprediction in EX this cycle
o_redirect_pc  output  32  correct next PC when o_mispred = 1
o_br_count  output  32  resolved control-flow instructions
o_mispred_count  output  32  mispredictions

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2].
- Each entry holds: valid bit, tag, 32-bit target, 2-bit saturating counter (00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken).
- Lookup is combinational, zero latency.
  - hit = valid & tag match.
  - o_IF_pred_taken = hit & counter[1].
  - o_IF_next_pc = o_IF_pred_taken ? entry target : i_IF_pc + 4 (32-bit add, wraps modulo 2^32).
- Update occurs on the rising edge when i_EX_vld = 1, at the entry indexed by i_EX_pc:
  - Hit, i_EX_is_jump = 1: counter := 11; target := i_EX_target.
  - Hit, branch taken: counter := min(counter+1, 11); target := i_EX_target.
  - Hit, branch not taken: counter := max(counter-1, 00); target unchanged.
  - Miss and taken: allocate or replace the entry. valid := 1, tag := EX tag, target := i_EX_target, counter := 11 for a jump, 10 for a branch.
  - Miss and not taken: no change.
- Misprediction (combinational, qualified by i_EX_vld):
  - o_mispred = i_EX_vld & ((i_EX_taken != i_EX_pred_taken) | (i_EX_taken & i_EX_target != i_EX_pred_target)).
  - o_redirect_pc = i_EX_taken ? i_EX_target : i_EX_pc + 4.
  - o_mispred = 0 whenever i_EX_vld = 0.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update entry contents (read-before-write).
- Counters:
  - o_br_count += 1 on every i_EX_vld cycle.
  - o_mispred_count += 1 on every o_mispred cycle.
  - Both wrap from 0xFFFFFFFF to 0.
- Reset (synchronous, i_reset = 1 at a rising edge):
  - All valid bits := 0, all counters := 01, o_br_count := 0, o_mispred_count := 0.
  - Targets and tags are don't-care.
  - After reset: o_IF_pred_taken = 0 and o_IF_next_pc = i_IF_pc + 4 for every PC.
  - Reset takes priority over an update in the same cycle.
  - Reset during a run discards all training.
- i_EX_pc[1:0] and i_IF_pc[1:0] are ignored.
- The predictor never stalls and has no internal FSM beyond the per-entry counters.

Test Plan:
1. Reset, then drive i_IF_pc = 0x0000_0100 → o_IF_pred_taken = 0, o_IF_next_pc = 0x0000_0104, both statistics counters = 0.
2. Resolve a taken branch at 0x100 to target 0x80, with pred_taken = 0 → o_mispred = 1, o_redirect_pc = 0x80. On the next cycle, lookup of 0x100 gives pred_taken = 1, next_pc = 0x80, and o_mispred_count = 1.
3. Train 0x100 not-taken twice from counter 10 → the counter moves 10→01→00, and lookup gives next_pc = 0x104. One further not-taken update keeps the counter at 00.
4. Aliasing: with ENTRIES = 64, PCs 0x100 and 0x200 share index 0. Taken 0x100 and then taken 0x200 → lookup of 0x100 misses (predicts 0x104); lookup of 0x200 hits.
5. Jump: jal at 0x40 to 0x400 → after one update, lookup predicts 0x400 and the counter = 11. Then resolve with target 0x400 and pred_target 0x404 → o_mispred = 1.
6. Same-cycle case: update 0x100 (taken to 0x80) while i_IF_pc = 0x100 → the same-cycle lookup returns the old prediction and the following cycle returns the new one. Pulsing i_reset mid-sequence clears all training and both counters.
